// File: rtl/spi_master_if.sv
// Controller handshake plus SPI pin bundle for spi_master.
// The master modport is the DUT view; slave is the controller/pin side.
interface spi_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  cpol;
  logic                  cpha;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  sclk;
  logic                  css;
  logic                  mosi;
  logic                  miso;

  modport master (
    input  start, tx_data, cpol, cpha, miso,
    output busy, done, rx_data, sclk, css, mosi
  );

  modport slave (
    output start, tx_data, cpol, cpha, miso,
    input  busy, done, rx_data, sclk, css, mosi
  );
endinterface

// File: rtl/spi_master.sv
// Single-slave SPI master, LSB first, all four CPOL/CPHA modes per transfer.
// Pin outputs come from registers; only sclk in IDLE follows the cpol input.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int CNT_W      = 8
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.master bus
);
  localparam int              EW      = $clog2(2*DATA_WIDTH+1);
  localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(CLK_DIV-1);
  localparam logic [EW-1:0]    LAST    = EW'(2*DATA_WIDTH);
  localparam logic [EW-1:0]    FIRST   = EW'(1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, FINISH} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [EW-1:0]         ecnt_q, ecnt_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rxdata_q, rxdata_d;
  logic                  sclk_q, sclk_d;
  logic                  css_q, css_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;

  logic          tick, lead, smp, shf;
  logic [EW-1:0] t_e;

  assign tick = (cnt_q == TICK_AT);
  assign t_e  = ecnt_q + 1'b1;   // 1-based index of the SCLK edge this tick makes
  assign lead = t_e[0];          // odd edges move SCLK away from idle
  assign smp  = lead ^ cpha_q;   // cpha=0 samples leading, cpha=1 trailing
  // The other edge shifts, except the final trailing (cpha=0) or first leading (cpha=1)
  assign shf  = !smp && (cpha_q ? (t_e != FIRST) : (t_e != LAST));

  // State and datapath next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ecnt_d   = ecnt_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rxdata_d = rxdata_q;
    sclk_d   = sclk_q;
    css_d    = css_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          tx_d    = bus.tx_data;
          mosi_d  = bus.tx_data[0];
          sclk_d  = bus.cpol;
          css_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          ecnt_d  = '0;
          rx_d    = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          ecnt_d = t_e;
          if (smp) rx_d = {bus.miso, rx_q[DATA_WIDTH-1:1]};
          if (shf) begin
            tx_d   = tx_q >> 1;
            mosi_d = tx_q[1];
          end
          if (t_e == LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          cnt_d    = '0;
          css_d    = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          rxdata_d = rx_q;
          mosi_d   = 1'b0;
          state_d  = FINISH;
        end
      end
      FINISH: begin
        ecnt_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and pin registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      ecnt_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rxdata_q <= '0;
      sclk_q   <= 1'b0;
      css_q    <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ecnt_q   <= ecnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rxdata_q <= rxdata_d;
      sclk_q   <= sclk_d;
      css_q    <= css_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
    end
  end

  assign bus.sclk    = (state_q == IDLE) ? bus.cpol : sclk_q;
  assign bus.css     = css_q;
  assign bus.mosi    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rxdata_q;
endmodule
